// File: rtl/pipeline_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the ID-stage stall/flush sequencer.
//   hazard_state_e  : sequencer state (RUN / MD_BUSY)
//   MD_LATENCY_MIN  : shortest supported MUL/DIV EX occupancy
//   MD_LATENCY_MAX  : longest supported MUL/DIV EX occupancy
//   md_cnt_width()  : width of the MUL/DIV down-counter for a given latency
//   md_reload()     : value loaded into the down-counter when an op is seen
// -----------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } hazard_state_e;

  localparam int MD_LATENCY_MIN = 2;
  localparam int MD_LATENCY_MAX = 16;

  // A latency of 2 gives $clog2 = 1; keep at least one bit regardless.
  function automatic int md_cnt_width(input int lat);
    int w;
    w = $clog2(lat);
    return (w < 1) ? 1 : w;
  endfunction

  // The detection cycle is the first hold cycle and the release cycle is the
  // last one, so the counter only has to cover latency-2 cycles in between.
  // Out-of-range latencies are clamped into the supported window.
  function automatic int md_reload(input int lat);
    int l;
    l = lat;
    if (l < MD_LATENCY_MIN) l = MD_LATENCY_MIN;
    if (l > MD_LATENCY_MAX) l = MD_LATENCY_MAX;
    return l - 2;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundle between the pipeline datapath and the hazard sequencer.
//   master modport : pipeline side, drives the ID/EX observations and
//                    receives the advance/flush/hold controls
//   slave  modport : the sequencer itself
// Observations : IFID_Rs1/Rs2, IFID_UsesRs1/UsesRs2, IDEX_Rd, IDEX_MemRead,
//                IDEX_MulDiv, Branch_Taken
// Controls     : PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, EX_Hold,
//                MD_Start, StallCount[CNT_W]
// -----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);

  logic [4:0]       IFID_Rs1;
  logic [4:0]       IFID_Rs2;
  logic             IFID_UsesRs1;
  logic             IFID_UsesRs2;
  logic [4:0]       IDEX_Rd;
  logic             IDEX_MemRead;
  logic             IDEX_MulDiv;
  logic             Branch_Taken;

  logic             PC_Write;
  logic             IFID_Write;
  logic             IDEX_Bubble;
  logic             IFID_Flush;
  logic             EX_Hold;
  logic             MD_Start;
  logic [CNT_W-1:0] StallCount;

  modport master (
    output IFID_Rs1, IFID_Rs2, IFID_UsesRs1, IFID_UsesRs2,
           IDEX_Rd, IDEX_MemRead, IDEX_MulDiv, Branch_Taken,
    input  PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush,
           EX_Hold, MD_Start, StallCount
  );

  modport slave (
    input  IFID_Rs1, IFID_Rs2, IFID_UsesRs1, IFID_UsesRs2,
           IDEX_Rd, IDEX_MemRead, IDEX_MulDiv, Branch_Taken,
    output PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush,
           EX_Hold, MD_Start, StallCount
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Purely combinational load-use compare for one ID-stage instruction against
// the load currently in EX. Kept standalone so a second issue slot can reuse it.
//   rs1, rs2            : source registers of the ID instruction
//   uses_rs1, uses_rs2  : the ID instruction really reads that source
//   rd                  : destination of the EX instruction
//   mem_read            : the EX instruction is a load
//   hazard              : the ID instruction must wait one cycle
// -----------------------------------------------------------------------------
module load_use_detect (
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       uses_rs1,
  input  logic       uses_rs2,
  input  logic [4:0] rd,
  input  logic       mem_read,
  output logic       hazard
);

  logic rs1_match;
  logic rs2_match;

  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign rs1_match = uses_rs1 && (rd == rs1);
  assign rs2_match = uses_rs2 && (rd == rs2);
  assign hazard    = mem_read && (rd != 5'd0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// ID-stage stall/flush sequencer for the 5-stage pipeline. Freezes the front
// end for load-use hazards and for multi-cycle MUL/DIV ops in EX, generates
// the IF/ID flush for taken branches, and counts stall cycles.
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-high reset
//   hz     : slave side of pipeline_hazard_ctrl_if (observations in,
//            PC_Write/IFID_Write/IDEX_Bubble/IFID_Flush/EX_Hold/MD_Start/
//            StallCount out)
// Parameters:
//   MD_LATENCY : EX occupancy of a MUL/DIV op in cycles (2..16)
//   CNT_W      : StallCount width, must match the interface CNT_W
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  pipeline_hazard_ctrl_if.slave  hz
);

  localparam int                  CNT_BITS   = md_cnt_width(MD_LATENCY);
  localparam logic [CNT_BITS-1:0] CNT_RELOAD = CNT_BITS'(md_reload(MD_LATENCY));

  hazard_state_e     state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]  stall_count_q;

  logic load_use;
  logic md_detect;
  logic md_holding;

  logic pc_write;
  logic ifid_write;
  logic idex_bubble;
  logic ifid_flush;
  logic ex_hold;
  logic md_start;

  load_use_detect u_load_use (
    .rs1      (hz.IFID_Rs1),
    .rs2      (hz.IFID_Rs2),
    .uses_rs1 (hz.IFID_UsesRs1),
    .uses_rs2 (hz.IFID_UsesRs2),
    .rd       (hz.IDEX_Rd),
    .mem_read (hz.IDEX_MemRead),
    .hazard   (load_use)
  );

  // A new MUL/DIV is only picked up from RUN; the release cycle of MD_BUSY
  // deliberately does not re-detect the op that is just leaving EX.
  assign md_detect  = (state_q == RUN) && hz.IDEX_MulDiv;
  assign md_holding = (state_q == MD_BUSY) && (cnt_q != '0);

  // State register: RUN/MD_BUSY and the MUL/DIV down-counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: enter MD_BUSY on detection, count down the remaining
  // hold cycles, and drop back to RUN on the release cycle (cnt == 0).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (md_detect) begin
          state_d = MD_BUSY;
          cnt_d   = CNT_RELOAD;
        end
      end
      MD_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_BITS'(1);
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic. Priority is MUL/DIV hold > load-use stall > branch flush;
  // the release cycle falls through to the ordinary RUN behaviour. Outputs are
  // forced to their idle values while reset is asserted so a MUL/DIV still
  // sitting in EX cannot fire MD_Start during reset.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    ex_hold     = 1'b0;
    md_start    = 1'b0;
    if (rst_i) begin
      pc_write = 1'b1;
    end else if (md_holding) begin
      ex_hold    = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (md_detect) begin
      ex_hold    = 1'b1;
      md_start   = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else begin
      ifid_flush = hz.Branch_Taken;
    end
  end

  // Stall-cycle counter: counts every cycle the PC is frozen and sticks at
  // all-ones instead of wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_count_q <= '0;
    end else if (!pc_write && (stall_count_q != '1)) begin
      stall_count_q <= stall_count_q + CNT_W'(1);
    end
  end

  assign hz.PC_Write    = pc_write;
  assign hz.IFID_Write  = ifid_write;
  assign hz.IDEX_Bubble = idex_bubble;
  assign hz.IFID_Flush  = ifid_flush;
  assign hz.EX_Hold     = ex_hold;
  assign hz.MD_Start    = md_start;
  assign hz.StallCount  = stall_count_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Stall/flush sequencer for the 5-stage RISC-V pipeline, sitting in ID beside the forwarding unit. It detects load-use hazards and sequences a multi-cycle MUL/DIV occupying EX by freezing the front end. It also generates the IF/ID flush for branches resolved in ID, and keeps a saturating stall-cycle counter for performance checks. Forwarding itself stays in the existing forwarding unit; this block only decides when the pipeline advances.

## Interface
Parameters:
- MD_LATENCY, 4, EX-stage occupancy in cycles of a MUL/DIV instruction; legal range 2..16.
- CNT_W, 16, width of StallCount.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- IFID_Rs1, IFID_Rs2  input  5 each  source registers of the instruction in ID.
- IFID_UsesRs1, IFID_UsesRs2  input  1 each  ID instruction actually reads Rs1/Rs2.
- IDEX_Rd  input  5  destination of the instruction in EX.
- IDEX_MemRead  input  1  EX instruction is a load.
- IDEX_MulDiv  input  1  EX instruction is a multi-cycle MUL/DIV.
- Branch_Taken  input  1  branch in ID resolved taken.
- PC_Write  output  1  PC may update.
- IFID_Write  output  1  IF/ID register may load.
- IDEX_Bubble  output  1  load a NOP into ID/EX.
- IFID_Flush  output  1  clear IF/ID to a NOP.
- EX_Hold  output  1  freeze ID/EX and load a bubble into EX/MEM; MEM/WB keep draining.
- MD_Start  output  1  one-cycle start pulse to the MUL/DIV unit.
- StallCount  output  CNT_W  saturating count of cycles with PC_Write=0.

## Operation
- State machine: RUN, MD_BUSY. Down-counter cnt holds $clog2(MD_LATENCY) bits.
- RUN with IDEX_MulDiv=1:
  - Assert EX_Hold, MD_Start. Drive PC_Write=IFID_Write=0.
  - Next state MD_BUSY, with cnt loaded to MD_LATENCY-2.
- MD_BUSY with cnt!=0:
  - Assert EX_Hold. Drive PC_Write=IFID_Write=0.
  - Decrement cnt. Ignore Branch_Taken, load-use and IDEX_MulDiv.
- MD_BUSY with cnt==0:
  - Release cycle: all outputs take RUN values, except that IDEX_MulDiv is not re-detected.
  - Next state RUN.
  - Result: EX_Hold is high for exactly MD_LATENCY-1 cycles.
- Load-use, RUN only, combinational:
  - Condition: IDEX_MemRead && IDEX_Rd!=0 && ((IFID_UsesRs1 && IDEX_Rd==IFID_Rs1) || (IFID_UsesRs2 && IDEX_Rd==IFID_Rs2)).
  - Response: PC_Write=IFID_Write=0 and IDEX_Bubble=1 for that cycle. No state change.
- Branch flush: IFID_Flush=Branch_Taken only when no load-use stall and no hold in the current cycle. Under a stall the branch re-evaluates next cycle.
- Priority: MD sequencing > load-use > branch flush. IDEX_MulDiv and IDEX_MemRead are never both high; if they are, MulDiv wins.
- StallCount:
  - Increments on each cycle with PC_Write=0.
  - Saturates at 2^CNT_W-1 and never wraps.

## Timing
- Load-use detection, branch flush and PC_Write/IFID_Write are combinational from inputs and state (zero latency). State, cnt and StallCount are registered.
- MD_Start is high only in the RUN detection cycle and never high in two consecutive cycles.
- Back-to-back MUL/DIV: the release cycle advances the first op. The second op, now in EX, is detected in the following RUN cycle.
- Output values under reset and in RUN with idle inputs: PC_Write=1, IFID_Write=1; IDEX_Bubble, IFID_Flush, EX_Hold, MD_Start and StallCount all 0.
- Reset asserted mid MD_BUSY: state immediately returns to RUN, cnt=0 and StallCount=0. No MD_Start is issued until a new IDEX_MulDiv is seen after reset is released.

## Structure
- Shared package (hazard_pkg):
  - State enum {RUN, MD_BUSY}.
  - MD_LATENCY_MIN=2, MD_LATENCY_MAX=16.
- Sub-module load_use_detect: purely combinational hazard compare on Rs1/Rs2/Rd. It is reusable by a future second issue slot.

## Test plan
- Load-use: IDEX_MemRead=1, IDEX_Rd=5, IFID_Rs2=5, IFID_UsesRs2=1 -> one cycle of PC_Write=0, IFID_Write=0, IDEX_Bubble=1. StallCount goes 0->1.
- No false hazard:
  - IDEX_Rd=0 with a matching Rs -> no stall.
  - IDEX_Rd=7 with IFID_Rs1=7 but IFID_UsesRs1=0 -> no stall.
- MUL/DIV with MD_LATENCY=4:
  - IDEX_MulDiv=1 -> MD_Start pulses once; EX_Hold=1 for exactly 3 cycles; PC_Write=0 for those 3 cycles; StallCount=3.
  - Branch_Taken held high throughout gives IFID_Flush=0 while held.
- Branch vs load-use:
  - Branch_Taken=1 together with a load-use hazard -> IFID_Flush=0 in that cycle.
  - Next cycle, with the hazard cleared -> IFID_Flush=1.
- Reset and saturation:
  - rst_i pulsed in the second MD_BUSY cycle -> outputs return to reset values asynchronously, with no further EX_Hold.
  - With CNT_W=4, 20 stall cycles -> StallCount=15.
